// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    // Smallest power of two >= n, never below 2 (FIFO pointer wrap relies on it).
    function automatic int pow2_ceil(input int n);
        int p;
        p = 2;
        while (p < n) p = p * 2;
        return p;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from storage (registered data).
// Latency: a push is visible at the head one cycle later.
// Backpressure: push ignored when full unless a pop frees the slot the same cycle; pop on empty ignored; clear wins over push/pop.
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == PTR_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty & ~clear;
    assign do_push  = push & (~full | do_pop) & ~clear;
    assign head_dat = mem[rd_ptr[IDX_W-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: owns the fetch PC, issues credit-limited memory requests, buffers {addr, inst} for the core.
// Latency: a response reaches inst_valid_o one cycle after its rvalid; no combinational path from mem_rdata_i.
// Backpressure: inst_ready_i low fills the FIFO; requests stop once buffered plus in-flight correct-path words reach DEPTH.
// Optional: define IFU_PERF_CNT_EN for perf_fetch_o / perf_discard_o saturating counters.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_discard_o
`endif
);

    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int AQ_DEPTH = pow2_ceil(MAX_OUTSTANDING);
    localparam int AQ_CNT_W = $clog2(AQ_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       pc;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  outstanding_nxt;
    logic [OUT_W-1:0]  discard;
    logic              credit_ok;
    logic              grant;
    logic              resp;
    logic              drop;
    logic              push;
    logic              pop;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    fifo_entry_t       fifo_head;
    fifo_entry_t       fifo_in;

    logic [31:0]       aq_head;
    logic              aq_full;
    logic              aq_empty;
    logic [AQ_CNT_W-1:0] aq_count;
    logic              unused_status;

    assign grant = mem_req_o & mem_gnt_i;
    // A response with nothing outstanding is a bus protocol error and is ignored.
    assign resp  = mem_rvalid_i & (outstanding != '0);
    assign drop  = resp & (discard != '0);
    // A correct-path response arriving with a jump is wrong-path after the redirect, so it is not kept.
    assign push  = resp & (discard == '0) & ~jump_en_i;
    assign pop   = inst_valid_o & inst_ready_i & ~jump_en_i;

    assign outstanding_nxt = outstanding + OUT_W'(grant) - OUT_W'(resp);

    // Credit: every correct-path word in flight already owns a FIFO slot.
    assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                       ((int'(fifo_count) + int'(outstanding) - int'(discard)) < DEPTH);

    // State register: one idle cycle after reset before fetching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_BOOT;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Request output; a redirect withdraws the request in its own cycle.
    always_comb begin
        mem_req_o = 1'b0;
        if (state == S_RUN && credit_ok && !jump_en_i) mem_req_o = 1'b1;
    end

    assign mem_addr_o = pc;

    // Fetch PC, in-flight count and wrong-path discard count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (jump_en_i) begin
                pc      <= jump_addr_i & 32'hFFFF_FFFC;
                // Everything still in flight after this cycle is wrong-path, including earlier discards.
                discard <= outstanding_nxt;
            end else begin
                if (grant) pc <= pc + 32'd4;
                if (drop)  discard <= discard - 1'b1;
            end
        end
    end

    // Addresses of granted requests, consumed in order as responses return.
    ifu_fifo #(
        .DEPTH (AQ_DEPTH),
        .WIDTH (32)
    ) u_addr_q (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .push     (grant),
        .push_dat (pc),
        .pop      (resp),
        .head_dat (aq_head),
        .full     (aq_full),
        .empty    (aq_empty),
        .count    (aq_count)
    );

    assign fifo_in = '{addr: aq_head, inst: mem_rdata_i};

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_data_q (
        .clk      (clk),
        .rst      (rst),
        .clear    (jump_en_i),
        .push     (push),
        .push_dat (fifo_in),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign unused_status = ^{aq_full, aq_empty, aq_count, fifo_full};

    assign inst_valid_o = ~fifo_empty;
    assign inst_o       = inst_valid_o ? fifo_head.inst : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? fifo_head.addr : 32'h0;

`ifdef IFU_PERF_CNT_EN
    logic [32:0] fetch_sum;
    logic [32:0] discard_sum;
    logic        resp_lost;

    assign resp_lost   = drop | (resp & (discard == '0) & jump_en_i);
    assign fetch_sum   = {1'b0, perf_fetch_o} + 33'(pop);
    assign discard_sum = {1'b0, perf_discard_o} + 33'(resp_lost) +
                         (jump_en_i ? 33'(fifo_count) : 33'd0);

    // Saturating event counters: delivered words, and dropped responses plus flushed entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_o   <= '0;
            perf_discard_o <= '0;
        end else begin
            perf_fetch_o   <= fetch_sum[32]   ? 32'hFFFF_FFFF : fetch_sum[31:0];
            perf_discard_o <= discard_sum[32] ? 32'hFFFF_FFFF : discard_sum[31:0];
        end
    end
`endif

    // Responses must only arrive for granted requests.
    a_rvalid_has_req : assert property (@(posedge clk) disable iff (rst)
        mem_rvalid_i |-> (outstanding != '0))
        else $error("ifu_prefetch: rvalid with no outstanding request");

endmodule

// File: tb/tb_ifu_prefetch.sv
// Table-driven directed bench for ifu_prefetch, plus a perf-counter sequence when IFU_PERF_CNT_EN is defined.
// Each row drives one cycle just after the rising edge and checks outputs at the falling edge.
// Expected values are hand-derived from the fetch/credit/redirect rules.
module tb_ifu_prefetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_iaddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_discard_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_o   (perf_fetch_o),
        .perf_discard_o (perf_discard_o)
`endif
    );

    // Memory data pattern for a given word address.
    function automatic logic [31:0] d(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic add(input logic r, input logic j, input logic [31:0] ja,
                       input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ia);
        vec_t v;
        v.rst = r; v.jump_en = j; v.jump_addr = ja;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev;
        v.e_inst  = ev ? ei : NOP;
        v.e_iaddr = ev ? ia : 32'h0;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic j, input logic [31:0] ja,
                        input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; jump_en_i = j; jump_addr_i = ja;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd; inst_ready_i = rdy;
        @(negedge clk);
    endtask

    initial begin
        // ---- 1: reset release, streaming fetch with ready=1 ----
        add(1,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            1,0,0,1,            0,32'h0,        0,0,0);
        add(0,0,0,            1,0,0,1,            1,32'h0,        0,0,0);
        add(0,0,0,            1,1,d(32'h0),1,     1,32'h4,        0,0,0);
        add(0,0,0,            1,1,d(32'h4),1,     1,32'h8,        1,d(32'h0),32'h0);
        add(0,0,0,            1,1,d(32'h8),1,     1,32'hC,        1,d(32'h4),32'h4);
        add(0,0,0,            0,1,d(32'hC),1,     1,32'h10,       1,d(32'h8),32'h8);
        add(0,0,0,            0,0,0,1,            1,32'h10,       1,d(32'hC),32'hC);
        add(0,0,0,            0,0,0,1,            1,32'h10,       0,0,0);
        // ---- 2: ready=0, FIFO fills to 4, then a single pop ----
        add(0,0,0,            1,0,0,0,            1,32'h10,       0,0,0);
        add(0,0,0,            1,1,d(32'h10),0,    1,32'h14,       0,0,0);
        add(0,0,0,            1,1,d(32'h14),0,    1,32'h18,       1,d(32'h10),32'h10);
        add(0,0,0,            1,1,d(32'h18),0,    1,32'h1C,       1,d(32'h10),32'h10);
        add(0,0,0,            1,1,d(32'h1C),0,    0,32'h20,       1,d(32'h10),32'h10);
        add(0,0,0,            1,0,0,0,            0,32'h20,       1,d(32'h10),32'h10);
        add(0,0,0,            1,0,0,1,            0,32'h20,       1,d(32'h10),32'h10);
        add(0,0,0,            1,0,0,0,            1,32'h20,       1,d(32'h14),32'h14);
        add(0,0,0,            1,1,d(32'h20),0,    0,32'h24,       1,d(32'h14),32'h14);
        // ---- 3: mid-run reset, two outstanding then redirect to 0x203 ----
        add(1,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,1,32'h10,       0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'h10,       0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'h14,       0,0,0);
        add(0,1,32'h203,      0,0,0,0,            0,32'h18,       0,0,0);
        add(0,0,0,            0,1,d(32'h10),0,    0,32'h200,      0,0,0);
        add(0,0,0,            1,1,d(32'h14),0,    1,32'h200,      0,0,0);
        add(0,0,0,            0,1,d(32'h200),0,   1,32'h204,      0,0,0);
        add(0,0,0,            0,0,0,1,            1,32'h204,      1,d(32'h200),32'h200);
        add(0,0,0,            0,0,0,0,            1,32'h204,      0,0,0);
        // ---- 4: redirect with a pop and a gnt offered in the same cycle ----
        add(1,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'h0,        0,0,0);
        add(0,0,0,            1,1,d(32'h0),0,     1,32'h4,        0,0,0);
        add(0,0,0,            1,1,d(32'h4),0,     1,32'h8,        1,d(32'h0),32'h0);
        add(0,1,32'h300,      1,0,0,1,            0,32'hC,        1,d(32'h0),32'h0);
        add(0,0,0,            0,1,d(32'h8),1,     1,32'h300,      0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'h300,      0,0,0);
        add(0,0,0,            0,1,d(32'h300),0,   1,32'h304,      0,0,0);
        add(0,0,0,            0,0,0,1,            1,32'h304,      1,d(32'h300),32'h300);
        // ---- 5: PC wrap from FFFF_FFFC, target low bits masked ----
        add(1,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,1,32'hFFFF_FFFE,0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'hFFFF_FFFC,0,0,0);
        add(0,0,0,            0,1,d(32'hFFFF_FFFC),0, 1,32'h0,    0,0,0);
        add(0,0,0,            0,0,0,1,            1,32'h0,        1,d(32'hFFFF_FFFC),32'hFFFF_FFFC);
        add(0,0,0,            0,0,0,0,            1,32'h0,        0,0,0);
        // ---- 7: second redirect while discard>0, with an rvalid in that cycle ----
        add(1,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            0,0,0,0,            0,32'h0,        0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'h0,        0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'h4,        0,0,0);
        add(0,1,32'h40,       0,0,0,0,            0,32'h8,        0,0,0);
        add(0,1,32'h80,       0,1,d(32'h0),0,     0,32'h40,       0,0,0);
        add(0,0,0,            0,1,d(32'h4),0,     1,32'h80,       0,0,0);
        add(0,0,0,            1,0,0,0,            1,32'h80,       0,0,0);
        add(0,0,0,            0,1,d(32'h80),0,    1,32'h84,       0,0,0);
        add(0,0,0,            0,0,0,1,            1,32'h84,       1,d(32'h80),32'h80);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            step(v.rst, v.jump_en, v.jump_addr, v.gnt, v.rvalid, v.rdata, v.ready);
            chk($sformatf("v%0d.mem_req", i),   32'(mem_req_o),    32'(v.e_req));
            chk($sformatf("v%0d.mem_addr", i),  mem_addr_o,        v.e_addr);
            chk($sformatf("v%0d.inst_valid", i),32'(inst_valid_o), 32'(v.e_valid));
            chk($sformatf("v%0d.inst", i),      inst_o,            v.e_inst);
            chk($sformatf("v%0d.inst_addr", i), inst_addr_o,       v.e_iaddr);
        end

`ifdef IFU_PERF_CNT_EN
        // ---- 6: deliver 5, flush 2 buffered entries, then reset clears counters ----
        step(1,0,0, 0,0,0,0);
        chk("perf_fetch_rst",   perf_fetch_o,   32'd0);
        chk("perf_discard_rst", perf_discard_o, 32'd0);
        step(0,0,0, 0,0,0,0);
        step(0,0,0, 1,0,0,1);
        for (int k = 0; k < 6; k++) step(0,0,0, 1,1,d(32'(k*4)),1);
        step(0,0,0, 0,1,d(32'h18),0);
        chk("perf_fetch_pre",   perf_fetch_o,   32'd5);
        chk("perf_buffered",    32'(inst_valid_o), 32'd1);
        step(0,1,32'h100, 0,0,0,0);
        step(0,0,0, 0,0,0,0);
        chk("perf_fetch",       perf_fetch_o,   32'd5);
        chk("perf_discard",     perf_discard_o, 32'd2);
        step(1,0,0, 0,0,0,0);
        chk("perf_fetch_mrst",  perf_fetch_o,   32'd0);
        chk("perf_discard_mrst",perf_discard_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
